// File: rtl/score_keeper_if.sv
// Line-clear handshake, soft-drop input and the statistics shown on the overlay.
// master = playfield side, slave = score_keeper.
interface score_keeper_if;
    logic        new_game;
    logic        clear_valid;
    logic [2:0]  clear_rows;
    logic        clear_ready;
    logic        soft_drop;
    logic [31:0] score;
    logic [31:0] level;
    logic [31:0] rows_cleared;
    logic        level_up;
    logic        busy;

    modport master (
        output new_game, clear_valid, clear_rows, soft_drop,
        input  clear_ready, score, level, rows_cleared, level_up, busy
    );

    modport slave (
        input  new_game, clear_valid, clear_rows, soft_drop,
        output clear_ready, score, level, rows_cleared, level_up, busy
    );
endinterface

// File: rtl/score_keeper.sv
// Score, level and rows-cleared statistics.
// Line-clear points are base * (level + 1), built by repeated addition.
//
// state  | meaning
// IDLE   | ready for a line-clear event
// ACCUM  | add base once per cycle, level+1 times
// COMMIT | fold acc into score, update rows and level
module score_keeper #(
    parameter int unsigned START_LEVEL    = 0,
    parameter int unsigned ROWS_PER_LEVEL = 10,
    parameter int unsigned MAX_LEVEL      = 99,
    parameter int unsigned MAX_SCORE      = 999999,
    parameter int unsigned MAX_ROWS       = 999
) (
    input logic           Clk,
    input logic           Reset,
    score_keeper_if.slave sk
);
    typedef enum logic [1:0] {IDLE, ACCUM, COMMIT} state_t;

    state_t      state, state_next;
    logic [2:0]  n_q;
    logic [31:0] base_q;
    logic [31:0] iter_q;
    logic [31:0] acc_q;
    logic [31:0] score_q;
    logic [31:0] level_q;
    logic [31:0] rows_q;
    logic [31:0] ril_q;
    logic        level_up_q;

    logic        clr;
    logic        ready_c;
    logic        valid_rows;
    logic        accept;
    logic [31:0] base_lut;
    logic [31:0] ril_sum;
    logic [31:0] rows_sum;
    logic [31:0] score_sum;

    function automatic logic [31:0] sat(input logic [31:0] v, input logic [31:0] m);
        return (v > m) ? m : v;
    endfunction

    assign clr        = Reset | sk.new_game;
    assign valid_rows = (sk.clear_rows != 3'd0) && (sk.clear_rows <= 3'd4);
    assign accept     = sk.clear_valid & ready_c;

    always_comb begin
        base_lut = 32'd0;
        case (sk.clear_rows)
            3'd1:    base_lut = 32'd40;
            3'd2:    base_lut = 32'd100;
            3'd3:    base_lut = 32'd300;
            3'd4:    base_lut = 32'd1200;
            default: base_lut = 32'd0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (clr) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready_c    = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (accept && valid_rows) state_next = ACCUM;
            end
            ACCUM: begin
                if (iter_q == 32'd1) state_next = COMMIT;
            end
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ril_sum   = ril_q + {29'd0, n_q};
    assign rows_sum  = rows_q + {29'd0, n_q};
    // soft_drop counts in every state, and stacks with a commit in the same cycle
    assign score_sum = score_q + ((state == COMMIT) ? acc_q : 32'd0) + {31'd0, sk.soft_drop};

    always_ff @(posedge Clk) begin
        if (clr) begin
            n_q        <= 3'd0;
            base_q     <= 32'd0;
            iter_q     <= 32'd0;
            acc_q      <= 32'd0;
            score_q    <= 32'd0;
            level_q    <= START_LEVEL;
            rows_q     <= 32'd0;
            ril_q      <= 32'd0;
            level_up_q <= 1'b0;
        end else begin
            level_up_q <= 1'b0;
            score_q    <= sat(score_sum, MAX_SCORE);
            case (state)
                IDLE: begin
                    if (accept && valid_rows) begin
                        n_q    <= sk.clear_rows;
                        base_q <= base_lut;
                        iter_q <= level_q + 32'd1;
                        acc_q  <= 32'd0;
                    end
                end
                ACCUM: begin
                    acc_q  <= acc_q + base_q;
                    iter_q <= iter_q - 32'd1;
                end
                COMMIT: begin
                    rows_q <= sat(rows_sum, MAX_ROWS);
                    if (ril_sum >= ROWS_PER_LEVEL) begin
                        ril_q <= ril_sum - ROWS_PER_LEVEL;
                        if (level_q < MAX_LEVEL) begin
                            level_q    <= level_q + 32'd1;
                            level_up_q <= 1'b1;
                        end
                    end else begin
                        ril_q <= ril_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sk.clear_ready  = ready_c;
    assign sk.busy         = ~ready_c;
    assign sk.score        = score_q;
    assign sk.level        = level_q;
    assign sk.rows_cleared = rows_q;
    assign sk.level_up     = level_up_q;
endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: a reference model pushes expected statistics
// when an event is accepted; they are popped when the DUT returns to IDLE.
module tb_score_keeper;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       sel = 1'b0;
    logic       ng = 1'b0;
    logic       cv = 1'b0;
    logic [2:0] cr = 3'd0;
    logic       sdrop = 1'b0;

    score_keeper_if ifa ();
    score_keeper_if ifb ();

    assign ifa.new_game    = ng & ~sel;
    assign ifa.clear_valid = cv & ~sel;
    assign ifa.clear_rows  = cr;
    assign ifa.soft_drop   = sdrop & ~sel;
    assign ifb.new_game    = ng & sel;
    assign ifb.clear_valid = cv & sel;
    assign ifb.clear_rows  = cr;
    assign ifb.soft_drop   = sdrop & sel;

    score_keeper dut_a (.Clk(clk), .Reset(rst), .sk(ifa));
    score_keeper #(.MAX_SCORE(2000)) dut_b (.Clk(clk), .Reset(rst), .sk(ifb));

    wire [31:0] cur_score = sel ? ifb.score        : ifa.score;
    wire [31:0] cur_level = sel ? ifb.level        : ifa.level;
    wire [31:0] cur_rows  = sel ? ifb.rows_cleared : ifa.rows_cleared;
    wire        cur_ready = sel ? ifb.clear_ready  : ifa.clear_ready;
    wire        cur_busy  = sel ? ifb.busy         : ifa.busy;
    wire        cur_lu    = sel ? ifb.level_up     : ifa.level_up;

    typedef struct {
        int unsigned score;
        int unsigned rows;
        int unsigned level;
        int unsigned lu;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    int unsigned m_score = 0;
    int unsigned m_level = 0;
    int unsigned m_rows  = 0;
    int unsigned m_ril   = 0;
    int unsigned m_max   = 999999;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int unsigned max_score);
        m_score = 0;
        m_level = 0;
        m_rows  = 0;
        m_ril   = 0;
        m_max   = max_score;
        sb.delete();
    endtask

    task automatic do_clear(input int rows, input bit sd, input bit hold);
        exp_t        e;
        int          lat;
        int unsigned base;
        int unsigned sum;
        chk("ready_before", {31'd0, cur_ready}, 32'd1);
        cv = 1'b1;
        cr = rows[2:0];
        lat = 0;
        if (rows >= 1 && rows <= 4) begin
            case (rows)
                1:       base = 40;
                2:       base = 100;
                3:       base = 300;
                default: base = 1200;
            endcase
            lat = int'(m_level) + 2;
            sum = m_score + base * (m_level + 1) + (sd ? 1 : 0);
            m_score = (sum > m_max) ? m_max : sum;
            m_rows = (m_rows + rows > 999) ? 999 : m_rows + rows;
            m_ril += rows;
            e.lu = 0;
            if (m_ril >= 10) begin
                m_ril -= 10;
                if (m_level < 99) begin
                    m_level++;
                    e.lu = 1;
                end
            end
            e.score = m_score;
            e.rows  = m_rows;
            e.level = m_level;
            sb.push_back(e);
        end
        @(negedge clk);
        if (!hold || lat == 0) cv = 1'b0;
        if (lat == 0) begin
            chk("drop_ready", {31'd0, cur_ready}, 32'd1);
            chk("drop_score", cur_score, m_score);
            chk("drop_rows", cur_rows, m_rows);
            return;
        end
        for (int c = 1; c <= lat; c++) begin
            chk("busy_ready", {31'd0, cur_ready}, 32'd0);
            chk("busy_flag", {31'd0, cur_busy}, 32'd1);
            sdrop = sd && (c == lat);
            @(negedge clk);
        end
        sdrop = 1'b0;
        cv = 1'b0;
        chk("ready_after", {31'd0, cur_ready}, 32'd1);
        chk("sb_depth", sb.size(), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("score", cur_score, e.score);
            chk("rows", cur_rows, e.rows);
            chk("level", cur_level, e.level);
            chk("level_up", {31'd0, cur_lu}, e.lu);
        end
        @(negedge clk);
        chk("level_up_clear", {31'd0, cur_lu}, 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_score"}, cur_score, 32'd0);
        chk({tag, "_level"}, cur_level, 32'd0);
        chk({tag, "_rows"}, cur_rows, 32'd0);
        chk({tag, "_ready"}, {31'd0, cur_ready}, 32'd1);
        chk({tag, "_lu"}, {31'd0, cur_lu}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // reset held for two edges
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");
        model_reset(999999);

        // single tetris at level 0, then 4 and 2 to reach level 1, then a single at level 1
        do_clear(4, 1'b0, 1'b0);
        do_clear(4, 1'b0, 1'b0);
        do_clear(2, 1'b0, 1'b0);
        do_clear(1, 1'b0, 1'b0);
        chk("after_single_score", cur_score, 32'd2580);

        // new_game during ACCUM discards the event
        cv = 1'b1;
        cr = 3'd4;
        @(negedge clk);
        cv = 1'b0;
        ng = 1'b1;
        @(negedge clk);
        ng = 1'b0;
        check_reset_vals("newgame");
        model_reset(999999);
        repeat (5) @(negedge clk);
        chk("newgame_late_score", cur_score, 32'd0);
        chk("newgame_late_rows", cur_rows, 32'd0);

        // soft_drop in the COMMIT cycle, dropped zero-row event, held valid during ACCUM
        do_clear(1, 1'b1, 1'b0);
        chk("sd_commit_score", cur_score, 32'd41);
        do_clear(0, 1'b0, 1'b0);
        do_clear(7, 1'b0, 1'b0);
        do_clear(2, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("hold_score", cur_score, 32'd141);
        chk("hold_rows", cur_rows, 32'd3);
        sdrop = 1'b1;
        @(negedge clk);
        sdrop = 1'b0;
        chk("sd_idle_score", cur_score, 32'd142);

        // score saturation on the MAX_SCORE=2000 instance
        sel = 1'b1;
        ng = 1'b1;
        @(negedge clk);
        ng = 1'b0;
        model_reset(2000);
        check_reset_vals("dutb");
        do_clear(4, 1'b0, 1'b0);
        chk("sat_first", cur_score, 32'd1200);
        do_clear(4, 1'b0, 1'b0);
        chk("sat_second", cur_score, 32'd2000);
        sdrop = 1'b1;
        @(negedge clk);
        sdrop = 1'b0;
        @(negedge clk);
        chk("sat_soft_drop", cur_score, 32'd2000);
        sel = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
